// File: rtl/uart_frame_parser.sv
// -----------------------------------------------------------------------------
// uart_frame_parser
//
// Parses framed messages arriving byte-by-byte from a UART receiver:
//     SYNC_BYTE, cmd, len, payload[len], checksum
// The checksum is the XOR of cmd, len and all payload bytes. Payload bytes
// are streamed out as they arrive. The frame ends in one of two ways:
//   - frame_done pulses when the checksum matches.
//   - frame_err pulses when the frame is aborted. err_code then gives the
//     reason (timeout, parity, length or checksum).
//
// Optional feature: define FRAME_TIMEOUT_EN to build an inter-byte timeout
// counter. Without it the parser waits indefinitely for the next byte.
//
// Parameters:
//   SYNC_BYTE       frame start marker
//   MAX_LEN         largest accepted payload length (1..255)
//   TIMEOUT_CYCLES  inter-byte timeout in clk cycles (FRAME_TIMEOUT_EN only)
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous active-high reset
//   rx_data        received byte, qualified by rx_done
//   rx_done        one-cycle byte strobe
//   rx_parity_err  parity error for the byte, qualified by rx_done
//   cmd, len       command and length of the current/last frame
//   pay_data       payload byte, qualified by pay_valid
//   pay_valid      one-cycle payload strobe
//   pay_index      zero-based payload byte index
//   frame_done     one-cycle pulse, frame accepted
//   frame_err      one-cycle pulse, frame aborted
//   err_code       abort reason: 0 timeout, 1 parity, 2 length, 3 checksum
//   busy           high whenever the parser is inside a frame
// -----------------------------------------------------------------------------
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 64,
    parameter int         TIMEOUT_CYCLES = 50_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       rx_parity_err,
    output logic [7:0] cmd,
    output logic [7:0] len,
    output logic [7:0] pay_data,
    output logic       pay_valid,
    output logic [7:0] pay_index,
    output logic       frame_done,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, CMD, LEN, PAYLOAD, CHECK} state_t;

    localparam logic [7:0] MAX_LEN_B   = 8'(MAX_LEN);
    localparam logic [1:0] ERR_TIMEOUT = 2'd0;
    localparam logic [1:0] ERR_PARITY  = 2'd1;
    localparam logic [1:0] ERR_LENGTH  = 2'd2;
    localparam logic [1:0] ERR_CHECK   = 2'd3;

    if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("uart_frame_parser: MAX_LEN must be 1..255 and TIMEOUT_CYCLES >= 1");
    end

    // Running checksum: one XOR fold step.
    function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    state_t     state_r, next_state_s;
    logic [7:0] cmd_r, cmd_s;
    logic [7:0] len_r, len_s;
    logic [7:0] acc_r, acc_s;
    logic [7:0] idx_r, idx_s;
    logic [7:0] pay_data_r, pay_data_s;
    logic [7:0] pay_index_r, pay_index_s;
    logic       pay_valid_r, pay_valid_s;
    logic       frame_done_r, frame_done_s;
    logic       frame_err_r, frame_err_s;
    logic [1:0] err_code_r, err_code_s;
    logic       busy_r;
    logic       tmo_hit_s;

`ifdef FRAME_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_r;

    // Inter-byte timeout counter: runs while inside a frame, restarts on every byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if (rx_done || !busy_r || tmo_hit_s) begin
            tmo_r <= {TMO_W{1'b0}};
        end else begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
        end
    end

    // A byte arriving in the terminal cycle takes priority over the timeout.
    assign tmo_hit_s = busy_r && !rx_done && (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_s = 1'b0;
`endif

    // Next-state and next-output decode for the frame FSM.
    always_comb begin
        next_state_s = state_r;
        cmd_s        = cmd_r;
        len_s        = len_r;
        acc_s        = acc_r;
        idx_s        = idx_r;
        pay_data_s   = pay_data_r;
        pay_index_s  = pay_index_r;
        pay_valid_s  = 1'b0;
        frame_done_s = 1'b0;
        frame_err_s  = 1'b0;
        err_code_s   = err_code_r;

        if (rx_done) begin
            if (state_r == IDLE) begin
                // Noise and corrupted bytes are dropped silently while hunting for sync.
                if (rx_data == SYNC_BYTE && !rx_parity_err) begin
                    next_state_s = CMD;
                end else begin
                    next_state_s = IDLE;
                end
            end else if (rx_parity_err) begin
                frame_err_s  = 1'b1;
                err_code_s   = ERR_PARITY;
                next_state_s = IDLE;
            end else begin
                case (state_r)
                    CMD: begin
                        cmd_s        = rx_data;
                        acc_s        = rx_data;
                        next_state_s = LEN;
                    end
                    LEN: begin
                        len_s = rx_data;
                        acc_s = csum_fold(acc_r, rx_data);
                        if (rx_data == 8'd0) begin
                            next_state_s = CHECK;
                        end else if (rx_data <= MAX_LEN_B) begin
                            idx_s        = 8'd0;
                            next_state_s = PAYLOAD;
                        end else begin
                            frame_err_s  = 1'b1;
                            err_code_s   = ERR_LENGTH;
                            next_state_s = IDLE;
                        end
                    end
                    PAYLOAD: begin
                        pay_data_s  = rx_data;
                        pay_index_s = idx_r;
                        pay_valid_s = 1'b1;
                        idx_s       = idx_r + 8'd1;
                        acc_s       = csum_fold(acc_r, rx_data);
                        // len_r is at least 1 here, so len_r - 1 cannot underflow.
                        if (idx_r == len_r - 8'd1) begin
                            next_state_s = CHECK;
                        end else begin
                            next_state_s = PAYLOAD;
                        end
                    end
                    CHECK: begin
                        if (rx_data == acc_r) begin
                            frame_done_s = 1'b1;
                        end else begin
                            frame_err_s = 1'b1;
                            err_code_s  = ERR_CHECK;
                        end
                        next_state_s = IDLE;
                    end
                    default: begin
                        next_state_s = IDLE;
                    end
                endcase
            end
        end else if (tmo_hit_s) begin
            frame_err_s  = 1'b1;
            err_code_s   = ERR_TIMEOUT;
            next_state_s = IDLE;
        end else begin
            next_state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            cmd_r        <= 8'd0;
            len_r        <= 8'd0;
            acc_r        <= 8'd0;
            idx_r        <= 8'd0;
            pay_data_r   <= 8'd0;
            pay_index_r  <= 8'd0;
            pay_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
            err_code_r   <= 2'd0;
            busy_r       <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cmd_r        <= cmd_s;
            len_r        <= len_s;
            acc_r        <= acc_s;
            idx_r        <= idx_s;
            pay_data_r   <= pay_data_s;
            pay_index_r  <= pay_index_s;
            pay_valid_r  <= pay_valid_s;
            frame_done_r <= frame_done_s;
            frame_err_r  <= frame_err_s;
            err_code_r   <= err_code_s;
            busy_r       <= (next_state_s != IDLE);
        end
    end

    assign cmd        = cmd_r;
    assign len        = len_r;
    assign pay_data   = pay_data_r;
    assign pay_index  = pay_index_r;
    assign pay_valid  = pay_valid_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign err_code   = err_code_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_uart_frame_parser.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_parser
//
// Randomized frames with noise, parity errors and bad lengths/checksums.
// A byte-position reference model builds the expected stream of events
// (payload strobes, done, error codes) and compares it with what the DUT emits.
// -----------------------------------------------------------------------------
module tb_uart_frame_parser;

    localparam int MAX_LEN = 64;
    localparam int TMO     = 100;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_err;
    logic [7:0] cmd, len, pay_data, pay_index;
    logic       pay_valid, frame_done, frame_err, busy;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .cmd           (cmd),
        .len           (len),
        .pay_data      (pay_data),
        .pay_valid     (pay_valid),
        .pay_index     (pay_index),
        .frame_done    (frame_done),
        .frame_err     (frame_err),
        .err_code      (err_code),
        .busy          (busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Event word: {type, code, index, data}; type 1 payload, 2 done, 3 error.
    function automatic logic [31:0] ev(input logic [7:0] t, input logic [1:0] c,
                                       input logic [7:0] i, input logic [7:0] d);
        return {t, 6'd0, c, i, d};
    endfunction

    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic [7:0]  pay_buf[256];
    logic [7:0]  exp_cmd = 8'd0;
    logic [7:0]  exp_len = 8'd0;

    // Monitor: record every output strobe.
    always @(negedge clk) begin
        if (pay_valid)  obs_q.push_back(ev(8'd1, 2'd0, pay_index, pay_data));
        if (frame_done) obs_q.push_back(ev(8'd2, 2'd0, 8'd0, 8'd0));
        if (frame_err)  obs_q.push_back(ev(8'd3, err_code, 8'd0, 8'd0));
    end

    initial begin
        #600_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b, input logic pe, input int gap);
        @(negedge clk);
        rx_data       = b;
        rx_done       = 1'b1;
        rx_parity_err = pe;
        @(negedge clk);
        rx_done       = 1'b0;
        rx_parity_err = 1'b0;
        rx_data       = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic compare_events(input string tag);
        repeat (3) @(negedge clk);
        check({tag, ":nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s:ev%0d", tag, i), obs_q[i], exp_q[i]);
        check({tag, ":busy"}, 32'(busy), 32'd0);
        check({tag, ":cmd"}, 32'(cmd), 32'(exp_cmd));
        check({tag, ":len"}, 32'(len), 32'(exp_len));
        obs_q.delete();
        exp_q.delete();
    endtask

    // Send one frame (payload in pay_buf) and predict its outcome byte by byte.
    // pe_pos is the byte position carrying a parity error, -1 for none.
    task automatic run_frame(input logic [7:0] c, input logic [7:0] l, input logic [7:0] k,
                             input int pe_pos, input string tag);
        logic [7:0] bytes[$];
        logic [7:0] x;
        bit         stop;
        bit         pe;
        bytes = {8'hA5, c, l};
        if (int'(l) <= MAX_LEN) begin
            for (int i = 0; i < int'(l); i++) bytes.push_back(pay_buf[i]);
            bytes.push_back(k);
        end
        stop = 1'b0;
        for (int i = 0; i < bytes.size() && !stop; i++) begin
            pe = (i == pe_pos);
            send_byte(bytes[i], pe, $urandom_range(0, 2));
            if (i == 0) begin
                if (pe) stop = 1'b1;
            end else if (pe) begin
                exp_q.push_back(ev(8'd3, 2'd1, 8'd0, 8'd0));
                stop = 1'b1;
            end else if (i == 1) begin
                exp_cmd = c;
            end else if (i == 2) begin
                exp_len = l;
                if (int'(l) > MAX_LEN) begin
                    exp_q.push_back(ev(8'd3, 2'd2, 8'd0, 8'd0));
                    stop = 1'b1;
                end
            end else if (i < 3 + int'(l)) begin
                exp_q.push_back(ev(8'd1, 2'd0, 8'(i - 3), bytes[i]));
            end else begin
                x = c ^ l;
                for (int j = 0; j < int'(l); j++) x = x ^ pay_buf[j];
                if (k == x) exp_q.push_back(ev(8'd2, 2'd0, 8'd0, 8'd0));
                else        exp_q.push_back(ev(8'd3, 2'd3, 8'd0, 8'd0));
            end
        end
        compare_events(tag);
    endtask

    initial begin
        logic [7:0] c, l, k, b;
        int         pe_pos, cnt, nb;

        reset         = 1'b1;
        rx_data       = 8'd0;
        rx_done       = 1'b0;
        rx_parity_err = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_cmd",   32'(cmd), 32'd0);
        check("rst_len",   32'(len), 32'd0);
        check("rst_pdata", 32'(pay_data), 32'd0);
        check("rst_pidx",  32'(pay_index), 32'd0);
        check("rst_pval",  32'(pay_valid), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_err",   32'(frame_err), 32'd0);
        check("rst_code",  32'(err_code), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        reset = 1'b0;

        // Noise in IDLE is ignored.
        send_byte(8'h00, 1'b0, 1);
        send_byte(8'hFF, 1'b0, 1);
        check("noise_busy", 32'(busy), 32'd0);

        pay_buf[0] = 8'h11;
        pay_buf[1] = 8'h22;
        run_frame(8'h01, 8'h02, 8'h30, -1, "basic");
        run_frame(8'h07, 8'h00, 8'h07, -1, "len0");
        run_frame(8'h07, 8'h00, 8'h08, -1, "badck");
        pay_buf[0] = 8'h11;
        pay_buf[1] = 8'h22;
        run_frame(8'h01, 8'h02, 8'h30, 3, "parity");
        run_frame(8'h01, 8'h02, 8'h30, 0, "sync_par");

        // Oversized length: error exactly one cycle after the len byte.
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h01, 1'b0, 0);
        @(negedge clk);
        rx_data = 8'h41;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("len_err_pulse", 32'(frame_err), 32'd1);
        check("len_err_code",  32'(err_code), 32'd2);
        check("len_err_busy",  32'(busy), 32'd0);
        exp_cmd = 8'h01;
        exp_len = 8'h41;
        exp_q.push_back(ev(8'd3, 2'd2, 8'd0, 8'd0));
        compare_events("len41");

        // Length boundaries.
        for (int i = 0; i < MAX_LEN; i++) pay_buf[i] = 8'($urandom);
        k = 8'h3C ^ 8'(MAX_LEN);
        for (int i = 0; i < MAX_LEN; i++) k = k ^ pay_buf[i];
        run_frame(8'h3C, 8'(MAX_LEN), k, -1, "maxlen");
        run_frame(8'h3C, 8'(MAX_LEN + 1), 8'h00, -1, "maxlen1");

        // Reset mid-frame aborts silently and clears cmd/len.
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h09, 1'b0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_cmd = 8'd0;
        exp_len = 8'd0;
        compare_events("midrst");

`ifdef FRAME_TIMEOUT_EN
        send_byte(8'hA5, 1'b0, 0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_err && cnt < 3 * TMO);
        check("tmo_cycles", 32'(cnt), 32'(TMO));
        check("tmo_code", 32'(err_code), 32'd0);
        exp_q.push_back(ev(8'd3, 2'd0, 8'd0, 8'd0));
        compare_events("tmo");
`else
        send_byte(8'hA5, 1'b0, 0);
        send_byte(8'h07, 1'b0, 0);
        repeat (3 * TMO) @(negedge clk);
        check("notmo_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b0, 0);
        send_byte(8'h07, 1'b0, 0);
        exp_cmd = 8'h07;
        exp_len = 8'h00;
        exp_q.push_back(ev(8'd2, 2'd0, 8'd0, 8'd0));
        compare_events("notmo");
`endif

        // Randomized frames.
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(0, 2);
            for (int n = 0; n < nb; n++) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                send_byte(b, 1'($urandom_range(0, 1)), 0);
            end
            c = 8'($urandom);
            case ($urandom_range(0, 9))
                7:       l = 8'($urandom_range(1, MAX_LEN));
                8:       l = 8'($urandom_range(MAX_LEN + 1, 255));
                default: l = 8'($urandom_range(0, 6));
            endcase
            for (int i = 0; i < int'(l) && i < MAX_LEN; i++) pay_buf[i] = 8'($urandom);
            k = c ^ l;
            for (int i = 0; i < int'(l) && i < MAX_LEN; i++) k = k ^ pay_buf[i];
            if ($urandom_range(0, 9) < 3) k = 8'($urandom);
            pe_pos = -1;
            if ($urandom_range(0, 3) == 0)
                pe_pos = $urandom_range(0, (int'(l) <= MAX_LEN) ? 3 + int'(l) : 2);
            run_frame(c, l, k, pe_pos, $sformatf("rnd%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
